perf_debug_monitor: RTL and testbench

- Parametrised on-chip debug/performance monitor for the GAT accelerator pipeline (SPMM, DMVM, softmax, aggregation stages and beyond).
- Tracks NUM_CH valid/ready channel pairs with sticky flags, first-event timestamps and saturating event counts.
- Captures up to NUM_CAP data words at a programmable address match.
- Exposes all results through a 1-cycle-latency word-read port, so firmware reads statistics instead of relying on hard-wired debug outputs.

---
 rtl/dbg_pkg.sv | 23 ++
 rtl/dbg_channel_stat.sv | 42 ++++
 rtl/perf_debug_monitor.sv | 157 +++++++++++++++
 tb/tb_perf_debug_monitor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared constants for the debug/performance monitor: FSM encodings, status word layout
// and read-map base addresses.
package dbg_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam int unsigned StatStateLsb  = 0;
  localparam int unsigned StatCapOvfBit = 2;
  localparam int unsigned StatCycSatBit = 3;
  localparam int unsigned StatCapPtrLsb = 4;
  localparam int unsigned StatCapPtrW   = 5;
  localparam int unsigned StatW         = StatCapPtrLsb + StatCapPtrW;

  localparam int unsigned RD_CH_BASE = 3;

  // Capture slots follow the three per-channel words of every channel.
  function automatic int unsigned rd_cap_base(input int unsigned num_ch);
    return RD_CH_BASE + 3 * num_ch;
  endfunction

endpackage

// File: rtl/dbg_channel_stat.sv
// Per-channel statistics: sticky valid/ready flags, first-event timestamps and a
// saturating valid counter, all updated only while the run is active.
module dbg_channel_stat #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic             vld,
  input  logic             rdy,
  input  logic [CNT_W-1:0] cycle_cnt,
  output logic             vld_seen,
  output logic             rdy_seen,
  output logic [CNT_W-1:0] vld_ts,
  output logic [CNT_W-1:0] rdy_ts,
  output logic [CNT_W-1:0] vld_cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld_seen <= 1'b0;
      rdy_seen <= 1'b0;
      vld_ts   <= '0;
      rdy_ts   <= '0;
      vld_cnt  <= '0;
    end else if (run) begin
      if (vld && !vld_seen) begin
        vld_seen <= 1'b1;
        vld_ts   <= cycle_cnt;
      end
      if (rdy && !rdy_seen) begin
        rdy_seen <= 1'b1;
        rdy_ts   <= cycle_cnt;
      end
      if (vld && (vld_cnt != {CNT_W{1'b1}})) begin
        vld_cnt <= vld_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_debug_monitor.sv
// Debug/performance monitor: run-control FSM, per-channel statistics, address-matched data
// capture and a one-cycle-latency word read port over all collected state.
module perf_debug_monitor
  import dbg_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned NUM_CAP   = 4,
  parameter int unsigned RD_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [NUM_CH-1:0]     ch_vld_i,
  input  logic [NUM_CH-1:0]     ch_rdy_i,
  input  logic                  cap_en_i,
  input  logic [ADDR_W-1:0]     cap_addr_i,
  input  logic [DATA_W-1:0]     cap_data_i,
  input  logic [ADDR_W-1:0]     cap_match_i,
  input  logic                  rd_en_i,
  input  logic [RD_ADDR_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic                  rd_vld_o,
  output logic [1:0]            state_o,
  output logic [2*NUM_CH-1:0]   flags_o
);

  logic [1:0]                      state_q;
  logic [CNT_W-1:0]                cycle_cnt_q;
  logic                            cyc_sat_q;
  logic [StatCapPtrW-1:0]          cap_ptr_q;
  logic                            cap_ovf_q;
  logic [NUM_CAP-1:0][DATA_W-1:0]  slot_q;
  logic [DATA_W-1:0]               rd_data_q;
  logic                            rd_vld_q;

  logic                            run;
  logic                            clr;
  logic                            cyc_max;
  logic [NUM_CH-1:0]               vld_seen;
  logic [NUM_CH-1:0]               rdy_seen;
  logic [NUM_CH-1:0][CNT_W-1:0]    vld_ts;
  logic [NUM_CH-1:0][CNT_W-1:0]    rdy_ts;
  logic [NUM_CH-1:0][CNT_W-1:0]    vld_cnt;
  logic [StatW-1:0]                status;
  logic [31:0]                     ra;
  logic [DATA_W-1:0]               rd_word;

  assign run     = (state_q == StRun);
  // A start accepted outside RUN wipes every statistic on the same edge.
  assign clr     = start_i && !run;
  assign cyc_max = (cycle_cnt_q == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cycle_cnt_q <= '0;
      cyc_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (stop_i || cyc_max) state_q <= StDone;
        end
        default: begin
          if (start_i) state_q <= StRun;
        end
      endcase
      if (clr) begin
        cycle_cnt_q <= '0;
        cyc_sat_q   <= 1'b0;
      end else if (run) begin
        if (cyc_max) cyc_sat_q <= 1'b1;
        else         cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dbg_channel_stat #(
      .CNT_W(CNT_W)
    ) u_stat (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .clr      (clr),
      .vld      (ch_vld_i[c]),
      .rdy      (ch_rdy_i[c]),
      .cycle_cnt(cycle_cnt_q),
      .vld_seen (vld_seen[c]),
      .rdy_seen (rdy_seen[c]),
      .vld_ts   (vld_ts[c]),
      .rdy_ts   (rdy_ts[c]),
      .vld_cnt  (vld_cnt[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cap_ptr_q <= '0;
      cap_ovf_q <= 1'b0;
      slot_q    <= '0;
    end else if (run && cap_en_i && (cap_addr_i == cap_match_i)) begin
      if (cap_ptr_q < StatCapPtrW'(NUM_CAP)) begin
        for (int k = 0; k < NUM_CAP; k++) begin
          if (cap_ptr_q == StatCapPtrW'(k)) slot_q[k] <= cap_data_i;
        end
        cap_ptr_q <= cap_ptr_q + StatCapPtrW'(1);
      end else begin
        cap_ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    status = '0;
    status[StatStateLsb +: 2]           = state_q;
    status[StatCapOvfBit]               = cap_ovf_q;
    status[StatCycSatBit]               = cyc_sat_q;
    status[StatCapPtrLsb +: StatCapPtrW] = cap_ptr_q;
  end

  assign ra = 32'(rd_addr_i);

  always_comb begin
    rd_word = '0;
    if (ra == 32'd0) rd_word = DATA_W'(status);
    if (ra == 32'd1) rd_word = DATA_W'(cycle_cnt_q);
    if (ra == 32'd2) rd_word = DATA_W'({rdy_seen, vld_seen});
    for (int c = 0; c < NUM_CH; c++) begin
      if (ra == 32'(RD_CH_BASE + 3 * c))     rd_word = DATA_W'(vld_ts[c]);
      if (ra == 32'(RD_CH_BASE + 3 * c + 1)) rd_word = DATA_W'(rdy_ts[c]);
      if (ra == 32'(RD_CH_BASE + 3 * c + 2)) rd_word = DATA_W'(vld_cnt[c]);
    end
    for (int k = 0; k < NUM_CAP; k++) begin
      if (ra == 32'(rd_cap_base(NUM_CH) + k)) rd_word = slot_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_en_i;
      if (rd_en_i) rd_data_q <= rd_word;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_vld_o  = rd_vld_q;
  assign state_o   = state_q;
  assign flags_o   = {rdy_seen, vld_seen};

endmodule

// File: tb/tb_perf_debug_monitor.sv
// Bench for perf_debug_monitor: a default instance plus a 4-bit-counter instance for
// saturation, with read results checked against a queue of expected words.
module tb_perf_debug_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [3:0]  vld;
  logic [3:0]  rdy;
  logic        cap_en;
  logic [15:0] cap_addr;
  logic [31:0] cap_data;
  logic [15:0] cap_match;
  logic        rd_en_m;
  logic        rd_en_s;
  logic [7:0]  rd_addr;

  logic [31:0] rd_data_m, rd_data_s;
  logic        rd_vld_m, rd_vld_s;
  logic [1:0]  state_m, state_s;
  logic [7:0]  flags_m, flags_s;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_m[$];
  logic [31:0] exp_s[$];
  string       tag_m[$];
  string       tag_s[$];

  always #5 clk = ~clk;

  perf_debug_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .stop_i     (stop),
    .ch_vld_i   (vld),
    .ch_rdy_i   (rdy),
    .cap_en_i   (cap_en),
    .cap_addr_i (cap_addr),
    .cap_data_i (cap_data),
    .cap_match_i(cap_match),
    .rd_en_i    (rd_en_m),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data_m),
    .rd_vld_o   (rd_vld_m),
    .state_o    (state_m),
    .flags_o    (flags_m)
  );

  perf_debug_monitor #(
    .CNT_W(4)
  ) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .stop_i     (stop),
    .ch_vld_i   (vld),
    .ch_rdy_i   (rdy),
    .cap_en_i   (cap_en),
    .cap_addr_i (cap_addr),
    .cap_data_i (cap_data),
    .cap_match_i(cap_match),
    .rd_en_i    (rd_en_s),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data_s),
    .rd_vld_o   (rd_vld_s),
    .state_o    (state_s),
    .flags_o    (flags_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one read; the expected word is queued for the matching monitor.
  task automatic rd(input bit sat, input logic [7:0] a, input logic [31:0] e, input string t);
    rd_addr = a;
    if (sat) begin
      rd_en_s = 1'b1;
      exp_s.push_back(e);
      tag_s.push_back(t);
    end else begin
      rd_en_m = 1'b1;
      exp_m.push_back(e);
      tag_m.push_back(t);
    end
    @(negedge clk);
    rd_en_m = 1'b0;
    rd_en_s = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (rd_vld_m) begin
      if (exp_m.size() == 0) check("rd_m_unexpected", 32'(exp_m.size()), 32'd1);
      else check(tag_m.pop_front(), rd_data_m, exp_m.pop_front());
    end
    if (rd_vld_s) begin
      if (exp_s.size() == 0) check("rd_s_unexpected", 32'(exp_s.size()), 32'd1);
      else check(tag_s.pop_front(), rd_data_s, exp_s.pop_front());
    end
  end

  function automatic logic [31:0] exp_run1(input int a);
    case (a)
      6:  return 32'd5;
      7:  return 32'd12;
      8:  return 32'd2;
      15: return 32'hA;
      16: return 32'hB;
      17: return 32'hC;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; vld = '0; rdy = '0;
    cap_en = 1'b0; cap_addr = '0; cap_data = '0; cap_match = '0;
    rd_en_m = 1'b0; rd_en_s = 1'b0; rd_addr = '0;
    step(3);
    rst = 1'b0;
    check("rst_state", state_m, 0);
    check("rst_flags", flags_m, 0);
    check("rst_rd_vld", rd_vld_m, 0);
    check("rst_rd_data", rd_data_m, 0);
    rd(0, 8'd0, 32'd0, "rst_status");

    // Saturation: 4-bit counter instance auto-stops at cycle_cnt 15.
    start = 1'b1; step(1); start = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      vld = 4'b0001;
      step(1);
    end
    vld = '0;
    check("sat_state", state_s, 2);
    rdy = 4'b0010; step(1); rdy = '0;
    check("sat_flags_frozen", flags_s, 8'h01);
    rd(1, 8'd0, 32'h0A, "sat_status");
    rd(1, 8'd1, 32'd15, "sat_cycle_cnt");
    rd(1, 8'd2, 32'h01, "sat_flag_word");
    rd(1, 8'd5, 32'd15, "sat_vld_cnt0");
    rd(1, 8'd7, 32'd0, "sat_rdy_ts1");
    stop = 1'b1; step(1); stop = 1'b0;
    step(3);
    check("sat_drain", 32'(exp_s.size()), 0);

    // Channel events and captures in one run.
    cap_match = 16'd10;
    start = 1'b1; step(1); start = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      vld      = (cyc == 5 || cyc == 9) ? 4'b0010 : 4'b0000;
      rdy      = (cyc == 12) ? 4'b0010 : 4'b0000;
      cap_en   = (cyc >= 1 && cyc <= 4);
      cap_addr = (cyc == 4) ? 16'd20 : 16'd10;
      cap_data = (cyc == 1) ? 32'hA : (cyc == 2) ? 32'hB : (cyc == 3) ? 32'hC : 32'hD;
      step(1);
    end
    vld = '0; rdy = '0; cap_en = 1'b0;
    stop = 1'b1; step(1); stop = 1'b0;
    check("run1_state", state_m, 2);
    check("run1_flags", flags_m, 8'h22);
    rd(0, 8'd0, 32'h32, "run1_status");
    rd(0, 8'd1, 32'd17, "run1_cycle_cnt");
    rd(0, 8'd2, 32'h22, "run1_flag_word");
    for (int a = 3; a < 20; a++) rd(0, 8'(a), exp_run1(a), $sformatf("run1_addr%0d", a));
    rd(0, 8'hFF, 32'd0, "run1_unmapped");
    rd(0, 8'd16, 32'hB, "run1_slot1");
    step(3);
    check("rd_vld_low", rd_vld_m, 0);
    check("rd_hold", rd_data_m, 32'hB);

    // Capture overflow.
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cap_en = 1'b1; cap_addr = 16'd10; cap_data = 32'(i);
      step(1);
    end
    cap_en = 1'b0;
    step(2);
    stop = 1'b1; step(1); stop = 1'b0;
    rd(0, 8'd0, 32'h46, "ovf_status");
    for (int k = 0; k < 4; k++) rd(0, 8'(15 + k), 32'(k + 1), $sformatf("ovf_slot%0d", k));
    rd(0, 8'd6, 32'd0, "ovf_vld_ts1_cleared");
    rd(0, 8'd2, 32'd0, "ovf_flags_cleared");

    // start ignored in RUN; start with stop ends the run.
    start = 1'b1; step(1); start = 1'b0;
    vld = 4'b0011; rdy = 4'b0001; step(1); vld = '0; rdy = '0;
    start = 1'b1; step(1); start = 1'b0;
    check("run_start_ignored_flags", flags_m, 8'h13);
    check("run_state", state_m, 1);
    rd(0, 8'd1, 32'd2, "run_cnt_not_restarted");
    cap_en = 1'b1; cap_addr = 16'd10; cap_data = 32'h77; step(1); cap_en = 1'b0;
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    check("start_stop_state", state_m, 2);
    rd(0, 8'd0, 32'h12, "start_stop_status");
    rd(0, 8'd1, 32'd5, "start_stop_cycle_cnt");
    rd(0, 8'd15, 32'h77, "start_stop_slot0");

    // Reset in the middle of a populated run.
    start = 1'b1; step(1); start = 1'b0;
    vld = 4'b1111; step(2); vld = '0;
    check("pre_rst_state", state_m, 1);
    rst = 1'b1; step(1); rst = 1'b0;
    check("mid_rst_state", state_m, 0);
    check("mid_rst_flags", flags_m, 0);
    check("mid_rst_rd_vld", rd_vld_m, 0);
    check("mid_rst_rd_data", rd_data_m, 0);
    for (int a = 0; a < 20; a++) rd(0, 8'(a), 32'd0, $sformatf("mid_rst_addr%0d", a));
    rd(0, 8'hFF, 32'd0, "mid_rst_unmapped");

    step(3);
    check("drain", 32'(exp_m.size() + exp_s.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
